e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  Multi-cycle multiply/divide unit in the E stage, downstream of the D->E pipeline register.
//  Consumes the forwarded rs/rt values and a decoded MDU opcode for the instruction in E.
//  Holds the architectural HI/LO registers and serves mfhi/mflo reads.
//  Exports a pending flag the hazard unit uses to stall MDU instructions held in D.
// PARAMETERS
//  MULT_LAT  5   busy cycles for mult/multu (>=1)
//  DIV_LAT   10  busy cycles for div/divu (>=1)
// PORTS
//  clk         in   1   clock, all state on posedge
//  reset       in   1   synchronous, active-high
//  start       in   1   E-stage instruction is valid and uses the MDU
//  op          in   4   MDU opcode (mdu_defs.vh)
//  rs_val      in   32  forwarded rs operand
//  rt_val      in   32  forwarded rt operand
//  busy        out  1   mult/div in progress (registered)
//  md_pending  out  1   busy | (start & op in {MULT,MULTU,DIV,DIVU}) (combinational)
//  hi          out  32  architectural HI
//  lo          out  32  architectural LO
//  rd_out      out  32  MFHI->hi, MFLO->lo, else 0 (combinational)
// BEHAVIOUR
//  Reset: hi=0, lo=0, busy=0, counter=0, state=IDLE; all outputs reset-valued next cycle.
//  Reset overrides everything, including an operation mid-flight (result discarded).
//  Opcodes: NONE=0 MULT=1 MULTU=2 DIV=3 DIVU=4 MFHI=5 MFLO=6 MTHI=7 MTLO=8; 9-15 = NONE.
//  FSM states: IDLE, MUL, DIV.
//   IDLE, start & MULT/MULTU at edge T: latch 64-bit product into tmp_hi/tmp_lo,
//    counter<=MULT_LAT, ->MUL; busy=1 from T through edge T+MULT_LAT.
//   IDLE, start & DIV/DIVU: latch quotient/remainder, counter<=DIV_LAT, ->DIV.
//   MUL/DIV: counter decrements each edge; on the edge where counter==1:
//    hi<=tmp_hi, lo<=tmp_lo, busy<=0, ->IDLE; result visible the next cycle.
//   busy is high for exactly LAT cycles; a new op may start the cycle busy falls.
//  MTHI/MTLO with start in IDLE: hi (lo) <= rs_val at that edge; one-cycle effect, no busy.
//  MFHI/MFLO: pure read, no state change; valid in any state (returns current hi/lo).
//  start with any op while busy=1: ignored, no state change (hazard unit prevents it).
//  Arithmetic:
//   MULT signed 32x32->64, MULTU unsigned; hi=prod[63:32], lo=prod[31:0].
//   DIV signed: lo=quotient truncated toward zero, hi=remainder with dividend's sign.
//   DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//   DIVU unsigned.
//   Divide by zero (both): full DIV_LAT busy, hi/lo left unchanged at completion.
//  md_pending covers the start cycle so a following MDU op in D stalls with zero gap.
// STRUCTURE
//  mdu_defs.vh: opcode localparams, FSM state encodings; shared with the controller.
//  Counter width: $clog2(max(MULT_LAT,DIV_LAT)+1).
//  No sub-module; arithmetic is inline, result latched at start to model latency only.
// TESTING
//  reset, then MULT rs=0xFFFFFFFE rt=3 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA.
//  MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001 after 5 cycles.
//  DIV rs=-7 rt=2 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF;
//   DIV 0x80000000/-1 -> lo=0x80000000 hi=0.
//  DIVU by 0 with hi=0x11,lo=0x22 preloaded via MTHI/MTLO -> busy 10, hi/lo unchanged;
//   MFHI -> rd_out=0x11.
//  MULT then start=1 MTLO 0x55 during busy -> ignored, lo=product;
//   md_pending=1 on start cycle and through busy.
//  reset asserted in cycle 3 of a DIV -> next cycle busy=0 hi=lo=0, no late write-back.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: opcode encodings, FSM states and decode helpers.
package e_mdu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 4;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // True for opcodes that occupy the unit for multiple cycles.
    function automatic logic is_md_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency with a
// down-counter, results computed at start and committed on the last busy cycle.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [XLEN-1:0]   rs_val,
    input  logic [XLEN-1:0]   rt_val,
    output logic              busy,
    output logic              md_pending,
    output logic [XLEN-1:0]   hi,
    output logic [XLEN-1:0]   lo,
    output logic [XLEN-1:0]   rd_out
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam int unsigned PROD_W  = 2 * XLEN;

    mdu_state_e          state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                busy_nxt;
    logic [XLEN-1:0]     hi_nxt, lo_nxt;
    logic [XLEN-1:0]     tmp_hi, tmp_lo, tmp_hi_nxt, tmp_lo_nxt;
    logic                wb_en, wb_en_nxt;

    logic [PROD_W-1:0]   prod_s, prod_u;
    logic [XLEN-1:0]     dvd_mag, dvs_mag, dvs_u;
    logic [XLEN-1:0]     quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;
    logic                dvs_zero;

    // Inline arithmetic on the forwarded operands; magnitude-based signed divide
    // so 0x80000000 / -1 wraps to 0x80000000 with remainder 0 naturally.
    always_comb begin
        prod_s   = {{XLEN{rs_val[XLEN-1]}}, rs_val} * {{XLEN{rt_val[XLEN-1]}}, rt_val};
        prod_u   = {{XLEN{1'b0}}, rs_val} * {{XLEN{1'b0}}, rt_val};
        dvs_zero = (rt_val == '0);
        dvd_mag  = rs_val[XLEN-1] ? (XLEN'(0) - rs_val) : rs_val;
        dvs_mag  = rt_val[XLEN-1] ? (XLEN'(0) - rt_val) : rt_val;
        if (dvs_zero) begin
            dvs_mag = XLEN'(1);
        end
        dvs_u    = dvs_zero ? XLEN'(1) : rt_val;
        quo_mag  = dvd_mag / dvs_mag;
        rem_mag  = dvd_mag % dvs_mag;
        quo_s    = (rs_val[XLEN-1] ^ rt_val[XLEN-1]) ? (XLEN'(0) - quo_mag) : quo_mag;
        rem_s    = rs_val[XLEN-1] ? (XLEN'(0) - rem_mag) : rem_mag;
        quo_u    = rs_val / dvs_u;
        rem_u    = rs_val % dvs_u;
    end

    // Hazard-unit view: covers the start cycle as well as the busy window.
    assign md_pending = busy | (start & is_md_op(op));

    // mfhi/mflo read port.
    always_comb begin
        rd_out = '0;
        if (op == OP_MFHI) begin
            rd_out = hi;
        end else if (op == OP_MFLO) begin
            rd_out = lo;
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            tmp_hi <= '0;
            tmp_lo <= '0;
            wb_en  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy   <= busy_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            tmp_hi <= tmp_hi_nxt;
            tmp_lo <= tmp_lo_nxt;
            wb_en  <= wb_en_nxt;
        end
    end

    // Next-state logic: accept ops only in IDLE, count down, commit on last cycle.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        busy_nxt   = busy;
        hi_nxt     = hi;
        lo_nxt     = lo;
        tmp_hi_nxt = tmp_hi;
        tmp_lo_nxt = tmp_lo;
        wb_en_nxt  = wb_en;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            if (op == OP_MULT) begin
                                tmp_hi_nxt = prod_s[PROD_W-1:XLEN];
                                tmp_lo_nxt = prod_s[XLEN-1:0];
                            end else begin
                                tmp_hi_nxt = prod_u[PROD_W-1:XLEN];
                                tmp_lo_nxt = prod_u[XLEN-1:0];
                            end
                            wb_en_nxt = 1'b1;
                            cnt_nxt   = CNT_W'(MULT_LAT);
                            busy_nxt  = 1'b1;
                            state_nxt = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (op == OP_DIV) begin
                                tmp_hi_nxt = rem_s;
                                tmp_lo_nxt = quo_s;
                            end else begin
                                tmp_hi_nxt = rem_u;
                                tmp_lo_nxt = quo_u;
                            end
                            // Divide by zero still occupies the unit but leaves HI/LO alone.
                            wb_en_nxt = ~dvs_zero;
                            cnt_nxt   = CNT_W'(DIV_LAT);
                            busy_nxt  = 1'b1;
                            state_nxt = ST_DIV;
                        end
                        OP_MTHI: hi_nxt = rs_val;
                        OP_MTLO: lo_nxt = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    if (wb_en) begin
                        hi_nxt = tmp_hi;
                        lo_nxt = tmp_lo;
                    end
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu against an arithmetic reference model.
module tb_e_mdu;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    localparam logic [3:0] O_NONE  = 4'd0;
    localparam logic [3:0] O_MULT  = 4'd1;
    localparam logic [3:0] O_MULTU = 4'd2;
    localparam logic [3:0] O_DIV   = 4'd3;
    localparam logic [3:0] O_DIVU  = 4'd4;
    localparam logic [3:0] O_MFHI  = 4'd5;
    localparam logic [3:0] O_MFLO  = 4'd6;
    localparam logic [3:0] O_MTHI  = 4'd7;
    localparam logic [3:0] O_MTLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, md_pending;
    logic [31:0] hi, lo, rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl_hi, mdl_lo;

    e_mdu #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .busy       (busy),
        .md_pending (md_pending),
        .hi         (hi),
        .lo         (lo),
        .rd_out     (rd_out)
    );

    always #5 clk = ~clk;

    // Reference model: architectural effect of one accepted op.
    task automatic model_apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          ps;
        longint unsigned pu;
        int              q, r;
        case (o)
            O_MULT: begin
                ps = longint'(signed'(a)) * longint'(signed'(b));
                pu = longint'(ps);
                mdl_hi = pu[63:32];
                mdl_lo = pu[31:0];
            end
            O_MULTU: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                mdl_hi = pu[63:32];
                mdl_lo = pu[31:0];
            end
            O_DIV: begin
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        mdl_lo = 32'h8000_0000;
                        mdl_hi = 32'h0;
                    end else begin
                        q = signed'(a) / signed'(b);
                        r = signed'(a) % signed'(b);
                        mdl_lo = q;
                        mdl_hi = r;
                    end
                end
            end
            O_DIVU: begin
                if (b != 0) begin
                    mdl_lo = a / b;
                    mdl_hi = a % b;
                end
            end
            O_MTHI: mdl_hi = a;
            O_MTLO: mdl_lo = a;
            default: ;
        endcase
    endtask

    function automatic int lat_of(input logic [3:0] o);
        if (o == O_MULT || o == O_MULTU) return MULT_LAT;
        if (o == O_DIV  || o == O_DIVU)  return DIV_LAT;
        return 0;
    endfunction

    // Issue one op from idle, check pending/read port, busy length and result.
    task automatic run_op(input string name, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        int          exp_lat;
        int          cnt;
        logic [31:0] exp_rd;
        exp_lat = lat_of(o);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        #1;
        n_checks++;
        if (md_pending !== (exp_lat != 0)) begin
            n_fail++;
            $display("FAIL %s pending_on_start: got %b want %b", name, md_pending, exp_lat != 0);
        end
        exp_rd = (o == O_MFHI) ? mdl_hi : (o == O_MFLO) ? mdl_lo : 32'h0;
        n_checks++;
        if (rd_out !== exp_rd) begin
            n_fail++;
            $display("FAIL %s rd_out: got %h want %h", name, rd_out, exp_rd);
        end
        model_apply(o, a, b);
        @(posedge clk); #1;
        start = 1'b0; op = O_NONE;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            n_checks++;
            if (md_pending !== 1'b1) begin
                n_fail++;
                $display("FAIL %s pending_in_busy: got %b want 1", name, md_pending);
            end
            cnt++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (cnt != exp_lat) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, cnt, exp_lat);
        end
        n_checks++;
        if (hi !== mdl_hi || lo !== mdl_lo) begin
            n_fail++;
            $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, mdl_hi, mdl_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = O_NONE; rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mdl_hi = '0; mdl_lo = '0;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || md_pending !== 1'b0 || rd_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b hi=%h lo=%h pend=%b rd=%h want all zero",
                     busy, hi, lo, md_pending, rd_out);
        end
    endtask

    task automatic test_directed();
        run_op("mult_neg2x3",   O_MULT,  32'hFFFF_FFFE, 32'd3);
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            n_fail++;
            $display("FAIL mult_const: got hi=%h lo=%h want ffffffff/fffffffa", hi, lo);
        end
        run_op("multu_max",     O_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_const: got hi=%h lo=%h want fffffffe/00000001", hi, lo);
        end
        run_op("div_m7_2",      O_DIV,   32'hFFFF_FFF9, 32'd2);
        n_checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_const: got hi=%h lo=%h want ffffffff/fffffffd", hi, lo);
        end
        run_op("div_overflow",  O_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        n_checks++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
            n_fail++;
            $display("FAIL div_ovf_const: got hi=%h lo=%h want 00000000/80000000", hi, lo);
        end
    endtask

    task automatic test_div_by_zero();
        run_op("mthi",      O_MTHI, 32'h11, 32'h0);
        run_op("mtlo",      O_MTLO, 32'h22, 32'h0);
        run_op("divu_zero", O_DIVU, 32'h1234_5678, 32'h0);
        run_op("div_zero",  O_DIV,  32'h8765_4321, 32'h0);
        n_checks++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            n_fail++;
            $display("FAIL divzero_keep: got hi=%h lo=%h want 11/22", hi, lo);
        end
        run_op("mfhi", O_MFHI, 32'h0, 32'h0);
        run_op("mflo", O_MFLO, 32'h0, 32'h0);
    endtask

    task automatic test_ignore_while_busy();
        logic [31:0] a, b;
        int          cnt;
        a = $urandom; b = $urandom;
        start = 1'b1; op = O_MULT; rs_val = a; rt_val = b;
        #1;
        n_checks++;
        if (md_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_pending_start: got %b want 1", md_pending);
        end
        model_apply(O_MULT, a, b);
        @(posedge clk); #1;
        op = O_MTLO; rs_val = 32'h55;
        #1;
        n_checks++;
        if (md_pending !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ign_busy_mtlo: got pend=%b busy=%b want 1/1", md_pending, busy);
        end
        @(posedge clk); #1;
        op = O_MULT; rs_val = 32'h7; rt_val = 32'h9;
        @(posedge clk); #1;
        start = 1'b0; op = O_NONE;
        cnt = 2;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (cnt != MULT_LAT) begin
            n_fail++;
            $display("FAIL ign_busy_cycles: got %0d want %0d", cnt, MULT_LAT);
        end
        n_checks++;
        if (hi !== mdl_hi || lo !== mdl_lo) begin
            n_fail++;
            $display("FAIL ign_result: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, mdl_hi, mdl_lo);
        end
    endtask

    task automatic test_reset_mid_div();
        run_op("pre_mthi", O_MTHI, 32'hAA, 32'h0);
        run_op("pre_mtlo", O_MTLO, 32'hBB, 32'h0);
        start = 1'b1; op = O_DIV; rs_val = 32'd1000; rt_val = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; op = O_NONE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_hi = '0; mdl_lo = '0;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_div: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        repeat (DIV_LAT + 2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_no_late_wb: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
    endtask

    // Random op stream issued back to back with zero idle gap.
    task automatic test_back_to_back();
        logic [3:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op("random", o, a, b);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_ignore_while_busy();
        test_reset_mid_div();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
